// File: rtl/dbus_pkg.sv
// Shared types and helpers for the dBus RAM responder: size lane masks,
// responder state encoding and byte-lane helpers.
package dbus_pkg;

  localparam logic [3:0] SIZE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_MASK_HALF = 4'b0011;
  localparam logic [3:0] SIZE_MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Lanes shifted past byte 3 fall off the 4-bit result.
  function automatic logic [3:0] lane_enables(input logic [3:0] size, input logic [1:0] lane);
    return size << lane;
  endfunction

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SIZE_MASK_BYTE) || (size == SIZE_MASK_HALF) || (size == SIZE_MASK_WORD);
  endfunction

  function automatic logic [31:0] lane_data_mask(input logic [3:0] size);
    return {{8{size[3]}}, {8{size[2]}}, {8{size[1]}}, {8{size[0]}}};
  endfunction

endpackage

// File: rtl/dbus_ram_bank.sv
// DEPTH_WORDS x 32 data RAM with per-byte write enables and a registered
// read port that holds its last read word until the next read.
module dbus_ram_bank #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic                           re,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = re ? mem[addr] : rdata_q;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dbus_ram_responder.sv
// dBus slave: byte-addressable word RAM, fixed-latency read responses and
// error flagging. Define DBUS_MISALIGN_CHECK_EN to reject misaligned half/word.
module dbus_ram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic [31:0] dBus_cmd_payload_addr,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [3:0]  dBus_cmd_payload_size,
  input  logic        dBus_cmd_payload_wr,
  output logic [31:0] dBus_rsp_data,
  output logic        dBus_rsp_valid,
  output logic        dBus_rsp_error
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_LOAD   = 4'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [1:0]  rd_lane_q, rd_lane_d;
  logic [3:0]  rd_size_q, rd_size_d;
  logic        rd_err_q, rd_err_d;

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [AW-1:0] widx;
  logic          in_range, misalign, cmd_err, accept;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic [31:0]   ram_wdata, ram_rdata;

  always_comb begin
    off       = dBus_cmd_payload_addr - BASE_ADDR;
    lane      = dBus_cmd_payload_addr[1:0];
    widx      = off[AW+1:2];
    in_range  = off < SPAN_BYTES;
`ifdef DBUS_MISALIGN_CHECK_EN
    misalign  = ((dBus_cmd_payload_size == SIZE_MASK_HALF) && lane[0]) ||
                ((dBus_cmd_payload_size == SIZE_MASK_WORD) && (lane != 2'd0));
`else
    misalign  = 1'b0;
`endif
    cmd_err   = !in_range || !size_legal(dBus_cmd_payload_size) || misalign;
    accept    = dBus_cmd_valid && ready_q;
    ram_we    = (accept && dBus_cmd_payload_wr && !cmd_err) ?
                lane_enables(dBus_cmd_payload_size, lane) : '0;
    ram_re    = accept && !dBus_cmd_payload_wr;
    ram_wdata = dBus_cmd_payload_data << {lane, 3'b000};
  end

  dbus_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .addr  (widx),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_lane_d = rd_lane_q;
    rd_size_d = rd_size_q;
    rd_err_d  = rd_err_q;

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accepts only happen in IDLE/RESP, so they override the default step.
    if (accept) begin
      if (dBus_cmd_payload_wr) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d     = LAT_LOAD;
        state_d   = (LAT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
        rd_lane_d = lane;
        rd_size_d = dBus_cmd_payload_size;
        rd_err_d  = cmd_err;
      end
    end

    ready_d     = (state_d != ST_WAIT);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_error_d = ((state_d == ST_RESP) && rd_err_d) ||
                  (accept && dBus_cmd_payload_wr && cmd_err);
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rd_lane_q   <= '0;
      rd_size_q   <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rd_lane_q   <= rd_lane_d;
      rd_size_q   <= rd_size_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign dBus_cmd_ready = ready_q;
  assign dBus_rsp_valid = rsp_valid_q;
  assign dBus_rsp_error = rsp_error_q;
  assign dBus_rsp_data  = (rsp_valid_q && !rd_err_q) ?
                          ((ram_rdata >> {rd_lane_q, 3'b000}) & lane_data_mask(rd_size_q)) : '0;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Bench for dbus_ram_responder: two instances (latency 1 and 3) checked
// against a byte-array memory model.
module tb_dbus_ram_responder;

  logic        clk = 1'b0;
  logic        rstf = 1'b1;
  logic [1:0]  cmd_valid = '0;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_wr = '0;
  logic [31:0] cmd_addr [2];
  logic [31:0] cmd_data [2];
  logic [3:0]  cmd_size [2];
  logic [31:0] rsp_data [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [2][4096];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dbus_ram_responder #(
      .DEPTH_WORDS  ((g == 0) ? 1024 : 16),
      .BASE_ADDR    ((g == 0) ? 32'h0000_0000 : 32'h0000_4000),
      .READ_LATENCY ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk                   (clk),
      .rstf                  (rstf),
      .dBus_cmd_valid        (cmd_valid[g]),
      .dBus_cmd_ready        (cmd_ready[g]),
      .dBus_cmd_payload_addr (cmd_addr[g]),
      .dBus_cmd_payload_data (cmd_data[g]),
      .dBus_cmd_payload_size (cmd_size[g]),
      .dBus_cmd_payload_wr   (cmd_wr[g]),
      .dBus_rsp_data         (rsp_data[g]),
      .dBus_rsp_valid        (rsp_valid[g]),
      .dBus_rsp_error        (rsp_error[g])
    );
  end

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_4000;
  endfunction

  function automatic logic [31:0] span_of(input int d);
    return (d == 0) ? 32'd4096 : 32'd64;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int nbytes(input logic [3:0] size);
    case (size)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic mdl_err(input int d, input logic [31:0] addr, input logic [3:0] size);
    logic [31:0] off;
    logic bad;
    off = addr - base_of(d);
    bad = (off >= span_of(d)) || (nbytes(size) == 0);
`ifdef DBUS_MISALIGN_CHECK_EN
    if (nbytes(size) == 2 && addr[0]) bad = 1'b1;
    if (nbytes(size) == 4 && addr[1:0] != 2'd0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input logic [31:0] addr, input logic [3:0] size);
    logic [31:0] off;
    logic [31:0] r;
    off = addr - base_of(d);
    r = '0;
    for (int i = 0; i < nbytes(size); i++)
      if (int'(off[1:0]) + i < 4) r[i*8 +: 8] = mbytes[d][int'(off) + i];
    return r;
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] size);
    logic [31:0] off;
    off = addr - base_of(d);
    for (int i = 0; i < nbytes(size); i++)
      if (int'(off[1:0]) + i < 4) mbytes[d][int'(off) + i] = data[i*8 +: 8];
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8) return base_of(d) + $urandom_range(0, span_of(d) - 1);
    else if (r == 8) return base_of(d) + span_of(d) + $urandom_range(0, 15);
    else return base_of(d) - 32'd1 - $urandom_range(0, 15);
  endfunction

  function automatic logic [3:0] rand_size();
    case ($urandom_range(0, 6))
      0, 1: return 4'b0001;
      2, 3: return 4'b0011;
      4, 5: return 4'b1111;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic wait_ready(input int d, input string tag);
    int n = 0;
    while (cmd_ready[d] !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s d=%0d ready timeout got=%b want=1", tag, d, cmd_ready[d]);
    end
  endtask

  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] size, input logic exp_err, input string tag);
    cmd_valid[d] = 1'b1;
    cmd_wr[d]    = 1'b1;
    cmd_addr[d]  = addr;
    cmd_data[d]  = data;
    cmd_size[d]  = size;
    wait_ready(d, tag);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    if (!exp_err) mdl_write(d, addr, data, size);
    checks++;
    if (rsp_valid[d] !== 1'b0 || rsp_error[d] !== exp_err || cmd_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s d=%0d addr=%h got valid=%b err=%b ready=%b want valid=0 err=%b ready=1",
               tag, d, addr, rsp_valid[d], rsp_error[d], cmd_ready[d], exp_err);
    end
  endtask

  task automatic do_read(input int d, input logic [31:0] addr, input logic [3:0] size,
                         input logic [31:0] exp_data, input logic exp_err, input string tag);
    logic [31:0] want;
    want = exp_err ? 32'h0 : exp_data;
    cmd_valid[d] = 1'b1;
    cmd_wr[d]    = 1'b0;
    cmd_addr[d]  = addr;
    cmd_data[d]  = $urandom;
    cmd_size[d]  = size;
    wait_ready(d, tag);
    for (int k = 1; k <= lat_of(d); k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid[d] = 1'b0;
      checks++;
      if (k < lat_of(d)) begin
        if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s d=%0d wait cycle %0d got valid=%b ready=%b want valid=0 ready=0",
                   tag, d, k, rsp_valid[d], cmd_ready[d]);
        end
      end else begin
        if (rsp_valid[d] !== 1'b1 || rsp_error[d] !== exp_err || rsp_data[d] !== want) begin
          errors++;
          $display("FAIL %s d=%0d addr=%h size=%b got valid=%b err=%b data=%h want valid=1 err=%b data=%h",
                   tag, d, addr, size, rsp_valid[d], rsp_error[d], rsp_data[d], exp_err, want);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstf = 1'b1;
    #2 rstf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cmd_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_error[d] !== 1'b0 || rsp_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs d=%0d got ready=%b valid=%b err=%b data=%h want all 0",
                 d, cmd_ready[d], rsp_valid[d], rsp_error[d], rsp_data[d]);
      end
    end
    rstf = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cmd_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready d=%0d got=%b want=1", d, cmd_ready[d]);
      end
    end
  endtask

  task automatic init_mem();
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b1;
      cmd_wr[d]    = 1'b1;
      cmd_size[d]  = 4'b1111;
      cmd_data[d]  = '0;
      for (int w = 0; w < int'(span_of(d)) / 4; w++) begin
        cmd_addr[d] = base_of(d) + 32'(w * 4);
        for (int b = 0; b < 4; b++) mbytes[d][w*4 + b] = 8'h00;
        @(negedge clk);
      end
      cmd_valid[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    do_write(0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, "st_word");
    do_read(0, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, "ld_word");
    do_write(0, 32'h11, 32'h000000A5, 4'b0001, 1'b0, "st_byte");
    do_read(0, 32'h10, 4'b1111, 32'hDEADA5EF, 1'b0, "ld_word_merged");
    do_read(0, 32'h11, 4'b0001, 32'h000000A5, 1'b0, "ld_byte");
    do_read(0, 32'h12, 4'b0011, 32'h0000DEAD, 1'b0, "ld_half_hi");
`ifdef DBUS_MISALIGN_CHECK_EN
    do_read(0, 32'h12, 4'b1111, 32'h0, 1'b1, "ld_word_misaligned");
`else
    do_read(0, 32'h12, 4'b1111, 32'h0000DEAD, 1'b0, "ld_word_misaligned");
`endif
  endtask

  task automatic test_errors();
    do_read(0, 32'h1000, 4'b1111, 32'h0, 1'b1, "ld_out_of_range");
    do_write(0, 32'h1000, 32'h12345678, 4'b1111, 1'b1, "st_out_of_range");
    @(negedge clk);
    checks++;
    if (rsp_error[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_len got err=%b valid=%b want err=0 valid=0", rsp_error[0], rsp_valid[0]);
    end
    do_read(0, 32'h0, 4'b1111, 32'h0, 1'b0, "ram_unchanged_oor");
    do_write(0, 32'h20, 32'hFFFFFFFF, 4'b0111, 1'b1, "st_bad_size");
    do_read(0, 32'h20, 4'b1111, 32'h0, 1'b0, "ram_unchanged_size");
    do_read(0, 32'h20, 4'b0111, 32'h0, 1'b1, "ld_bad_size");
    do_write(0, 32'hFFC, 32'hCAFEF00D, 4'b1111, 1'b0, "st_last_word");
    do_read(0, 32'hFFC, 4'b1111, 32'hCAFEF00D, 1'b0, "ld_last_word");
    do_read(1, 32'h3FFC, 4'b1111, 32'h0, 1'b1, "ld_below_base");
    do_read(1, 32'h4040, 4'b0001, 32'h0, 1'b1, "ld_past_end");
  endtask

  task automatic test_latency();
    do_write(1, 32'h4008, 32'h11223344, 4'b1111, 1'b0, "lat_st_a");
    do_write(1, 32'h400C, 32'h55667788, 4'b1111, 1'b0, "lat_st_b");
    cmd_valid[1] = 1'b1;
    cmd_wr[1]    = 1'b0;
    cmd_addr[1]  = 32'h4008;
    cmd_size[1]  = 4'b1111;
    wait_ready(1, "lat_first");
    @(negedge clk);
    cmd_addr[1] = 32'h400E;
    cmd_size[1] = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (k == 3 || k == 6) begin
        if (rsp_valid[1] !== 1'b1 || rsp_error[1] !== 1'b0 || cmd_ready[1] !== 1'b1 ||
            rsp_data[1] !== ((k == 3) ? 32'h11223344 : 32'h00005566)) begin
          errors++;
          $display("FAIL lat_resp cyc=%0d got valid=%b err=%b ready=%b data=%h want valid=1 err=0 ready=1 data=%h",
                   k, rsp_valid[1], rsp_error[1], cmd_ready[1], rsp_data[1],
                   (k == 3) ? 32'h11223344 : 32'h00005566);
        end
      end else begin
        if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b0) begin
          errors++;
          $display("FAIL lat_wait cyc=%0d got valid=%b ready=%b want valid=0 ready=0",
                   k, rsp_valid[1], cmd_ready[1]);
        end
      end
      @(negedge clk);
      if (k == 3) cmd_valid[1] = 1'b0;
    end
    checks++;
    if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL lat_after got valid=%b ready=%b want valid=0 ready=1", rsp_valid[1], cmd_ready[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic        prev_rd, prev_err, wr, e;
    logic [31:0] prev_data, addr, data, exp_d;
    logic [3:0]  size;
    prev_rd = 1'b0; prev_err = 1'b0; prev_data = '0;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        checks++;
        if (rsp_valid[0] !== prev_rd || rsp_error[0] !== prev_err || cmd_ready[0] !== 1'b1 ||
            (prev_rd && rsp_data[0] !== prev_data)) begin
          errors++;
          $display("FAIL b2b op=%0d got valid=%b err=%b ready=%b data=%h want valid=%b err=%b ready=1 data=%h",
                   i - 1, rsp_valid[0], rsp_error[0], cmd_ready[0], rsp_data[0], prev_rd, prev_err, prev_data);
        end
      end
      if (i < 40) begin
        wr   = ($urandom_range(0, 2) == 0);
        addr = rand_addr(0);
        size = rand_size();
        data = $urandom;
        e    = mdl_err(0, addr, size);
        exp_d = '0;
        if (!wr && !e) exp_d = mdl_read(0, addr, size);
        if (wr && !e) mdl_write(0, addr, data, size);
        cmd_valid[0] = 1'b1;
        cmd_wr[0]    = wr;
        cmd_addr[0]  = addr;
        cmd_data[0]  = data;
        cmd_size[0]  = size;
        prev_rd   = !wr;
        prev_err  = e;
        prev_data = exp_d;
      end else begin
        cmd_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data;
    logic [3:0]  size;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        addr = rand_addr(d);
        size = rand_size();
        data = $urandom;
        if ($urandom_range(0, 1) == 0)
          do_write(d, addr, data, size, mdl_err(d, addr, size), "rnd_st");
        else
          do_read(d, addr, size, mdl_read(d, addr, size), mdl_err(d, addr, size), "rnd_ld");
      end
    end
  endtask

  task automatic test_reset_mid_read();
    cmd_valid[1] = 1'b1;
    cmd_wr[1]    = 1'b0;
    cmd_addr[1]  = 32'h4008;
    cmd_size[1]  = 4'b1111;
    wait_ready(1, "mid_rst");
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    checks++;
    if (cmd_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_wait got ready=%b want=0", cmd_ready[1]);
    end
    rstf = 1'b0;
    #1;
    checks++;
    if (cmd_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || rsp_error[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_async got ready=%b valid=%b err=%b want 0 0 0", cmd_ready[1], rsp_valid[1], rsp_error[1]);
    end
    @(negedge clk);
    rstf = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b0 || rsp_error[1] !== 1'b0) begin
        errors++;
        $display("FAIL mid_rst_no_resp cyc=%0d got valid=%b err=%b want 0 0", k, rsp_valid[1], rsp_error[1]);
      end
    end
    do_read(1, 32'h4008, 4'b1111, mdl_read(1, 32'h4008, 4'b1111), 1'b0, "mid_rst_recover");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cmd_addr[d] = '0;
      cmd_data[d] = '0;
      cmd_size[d] = '0;
    end
    test_reset();
    init_mem();
    test_directed();
    test_errors();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
